// File: rtl/capture_ctrl.sv
// Multi-channel capture controller: circular sample buffer with programmable
// pre-/post-trigger split, abort, clamped trigger position and auto re-arm.
module capture_ctrl #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9,
  parameter int unsigned NCHAN   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_mode,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic [LOG2-1:0]  trig_pos,
  input  logic [NCHAN-1:0] chan_en,
  input  logic             wrt_smpl,
  input  logic             trig,
  input  logic             capture_done,
  output logic             armed,
  output logic             set_capture_done,
  output logic [NCHAN-1:0] we,
  output logic [LOG2-1:0]  waddr,
  output logic [LOG2-1:0]  trig_addr,
  output logic             busy
);

  localparam int unsigned CW = LOG2 + 1;
  typedef logic [CW-1:0]   cnt_t;
  typedef logic [LOG2-1:0] addr_t;
  localparam cnt_t  FULL = cnt_t'(ENTRIES);
  localparam addr_t LAST = addr_t'(ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE_HI, DONE_LO} state_t;

  state_t state;
  cnt_t   pre_cnt, post_cnt;
  cnt_t   tp, need, pre_nxt, post_nxt;
  addr_t  waddr_nxt;
  logic   capturing, stop, wr;

  // Clamp the requested post-trigger count into 1..ENTRIES
  always_comb begin
    tp = cnt_t'(trig_pos);
    if (trig_pos == '0)
      tp = cnt_t'(1);
    else if (cnt_t'(trig_pos) > FULL)
      tp = FULL;
  end

  assign need      = FULL - tp;
  assign capturing = (state == PRE) || (state == ARMED) || (state == POST);
  // A cancelled cycle neither writes nor advances the address
  assign stop      = abort || (capturing && !run_mode);
  assign wr        = capturing && wrt_smpl && !stop;
  assign we        = wr ? chan_en : '0;
  assign busy      = (state != IDLE);

  assign waddr_nxt = (waddr == LAST) ? '0 : waddr + addr_t'(1);
  assign pre_nxt   = (pre_cnt >= FULL) ? FULL : pre_cnt + cnt_t'(1);
  assign post_nxt  = post_cnt + cnt_t'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
      waddr            <= '0;
      trig_addr        <= '0;
      pre_cnt          <= '0;
      post_cnt         <= '0;
    end else begin
      set_capture_done <= 1'b0;
      if (wr)
        waddr <= waddr_nxt;

      if (stop) begin
        state <= IDLE;
        armed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (run_mode) begin
              waddr     <= '0;
              trig_addr <= '0;
              pre_cnt   <= '0;
              post_cnt  <= '0;
              state     <= PRE;
            end
          end
          PRE: begin
            if (wr)
              pre_cnt <= pre_nxt;
            if (pre_cnt >= need) begin
              armed <= 1'b1;
              state <= ARMED;
            end
          end
          ARMED: begin
            if (wr && trig) begin
              trig_addr <= waddr;
              post_cnt  <= cnt_t'(1);
              if (tp == cnt_t'(1)) begin
                state            <= DONE_HI;
                set_capture_done <= 1'b1;
                armed            <= 1'b0;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            if (wr) begin
              post_cnt <= post_nxt;
              if (post_nxt == tp) begin
                state            <= DONE_HI;
                set_capture_done <= 1'b1;
                armed            <= 1'b0;
              end
            end
          end
          DONE_HI: begin
            if (capture_done)
              state <= DONE_LO;
          end
          DONE_LO: begin
            if (!capture_done) begin
              if (cont_mode && run_mode) begin
                waddr     <= '0;
                trig_addr <= '0;
                pre_cnt   <= '0;
                post_cnt  <= '0;
                state     <= PRE;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl; every expected write is queued when the
// strobe is driven and matched against we/waddr by a negedge monitor.
module tb_capture_ctrl;

  localparam int unsigned ENTRIES = 384;
  localparam int unsigned LOG2    = 9;
  localparam int unsigned NCHAN   = 5;

  typedef logic [LOG2+NCHAN-1:0] ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run_mode = 1'b0;
  logic             abort = 1'b0;
  logic             cont_mode = 1'b0;
  logic [LOG2-1:0]  trig_pos = '0;
  logic [NCHAN-1:0] chan_en = '1;
  logic             wrt_smpl = 1'b0;
  logic             trig = 1'b0;
  logic             capture_done = 1'b0;
  logic             armed, set_capture_done, busy;
  logic [NCHAN-1:0] we;
  logic [LOG2-1:0]  waddr, trig_addr;

  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  int          early = 0;
  ent_t        exp_q[$];
  ent_t        mon_e;
  logic        cap = 1'b0;
  int unsigned m_addr = 0;

  always #5 clk = ~clk;

  capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2), .NCHAN(NCHAN)) dut (
    .clk(clk), .rst_n(rst_n), .run_mode(run_mode), .abort(abort),
    .cont_mode(cont_mode), .trig_pos(trig_pos), .chan_en(chan_en),
    .wrt_smpl(wrt_smpl), .trig(trig), .capture_done(capture_done),
    .armed(armed), .set_capture_done(set_capture_done), .we(we),
    .waddr(waddr), .trig_addr(trig_addr), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
  endtask

  // Write monitor: pops the scoreboard on every observed write
  always @(negedge clk) begin
    if (set_capture_done === 1'b1)
      pulses++;
    if (we !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(we), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("we_mask", 32'(we), 32'(mon_e[NCHAN-1:0]));
        chk("we_addr", 32'(waddr), 32'(mon_e[LOG2+NCHAN-1:NCHAN]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic t);
    wrt_smpl = 1'b1;
    trig     = t;
    if (cap) begin
      exp_q.push_back({LOG2'(m_addr), chan_en});
      m_addr = (m_addr + 1) % ENTRIES;
    end
    tick(1);
    wrt_smpl = 1'b0;
    trig     = 1'b0;
  endtask

  task automatic start_run(input logic [LOG2-1:0] tpos, input logic [NCHAN-1:0] mask);
    trig_pos = tpos;
    chan_en  = mask;
    run_mode = 1'b1;
    tick(1);
    m_addr = 0;
    cap    = 1'b1;
  endtask

  // Host handshake starting in the pulse cycle
  task automatic ack();
    tick(2);
    capture_done = 1'b1;
    tick(10);
    capture_done = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset state
    tick(1);
    strobe(1'b0);
    chk("rst_armed", 32'(armed), 32'(0));
    chk("rst_scd", 32'(set_capture_done), 32'(0));
    chk("rst_waddr", 32'(waddr), 32'(0));
    chk("rst_trig_addr", 32'(trig_addr), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;

    // Basic capture: trig_pos=100, trigger on write #300
    start_run(9'd100, 5'b11111);
    for (int k = 1; k <= 399; k++) begin
      if (k <= 285 && armed === 1'b1)
        early++;
      if (k == 286)
        chk("t1_armed_rise", 32'(armed), 32'(1));
      strobe(k == 300);
    end
    cap = 1'b0;
    chk("t1_early_armed", 32'(early), 32'(0));
    chk("t1_scd", 32'(set_capture_done), 32'(1));
    chk("t1_armed_clr", 32'(armed), 32'(0));
    chk("t1_trig_addr", 32'(trig_addr), 32'(299));
    chk("t1_waddr", 32'(waddr), 32'(15));
    run_mode = 1'b0;
    strobe(1'b0);
    chk("t1_scd_one_cycle", 32'(set_capture_done), 32'(0));
    strobe(1'b0);
    capture_done = 1'b1;
    tick(10);
    capture_done = 1'b0;
    tick(1);
    chk("t1_idle", 32'(busy), 32'(0));
    chk("t1_waddr_hold", 32'(waddr), 32'(15));
    chk("t1_pulses", 32'(pulses), 32'(1));
    chk("t1_q_empty", 32'(exp_q.size()), 32'(0));

    // trig held high from start: pre writes ignore it
    start_run(9'd100, 5'b11111);
    for (int k = 1; k <= 284; k++)
      strobe(1'b1);
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    chk("t2_armed", 32'(armed), 32'(1));
    for (int k = 1; k <= 100; k++)
      strobe(1'b1);
    cap = 1'b0;
    chk("t2_scd", 32'(set_capture_done), 32'(1));
    chk("t2_trig_addr", 32'(trig_addr), 32'(284));
    chk("t2_waddr", 32'(waddr), 32'(0));
    run_mode = 1'b0;
    ack();
    chk("t2_idle", 32'(busy), 32'(0));

    // Channel mask with gapped strobes, trig_pos=50
    start_run(9'd50, 5'b00101);
    for (int k = 1; k <= 389; k++) begin
      strobe(k == 340);
      if (k != 389)
        tick(1);
    end
    cap = 1'b0;
    chk("t3_scd", 32'(set_capture_done), 32'(1));
    chk("t3_trig_addr", 32'(trig_addr), 32'(339));
    chk("t3_waddr", 32'(waddr), 32'(5));
    run_mode = 1'b0;
    ack();

    // trig_pos=0 behaves as 1
    start_run(9'd0, 5'b11111);
    for (int k = 1; k <= 390; k++)
      strobe(k == 390);
    cap = 1'b0;
    chk("t4_scd", 32'(set_capture_done), 32'(1));
    chk("t4_trig_addr", 32'(trig_addr), 32'(5));
    chk("t4_waddr", 32'(waddr), 32'(6));
    run_mode = 1'b0;
    ack();

    // trig_pos=511 behaves as ENTRIES: armed with no pre writes
    start_run(9'd511, 5'b11111);
    chk("t5_armed_pre", 32'(armed), 32'(0));
    tick(1);
    chk("t5_armed", 32'(armed), 32'(1));
    for (int k = 1; k <= 384; k++)
      strobe(k == 1);
    cap = 1'b0;
    chk("t5_scd", 32'(set_capture_done), 32'(1));
    chk("t5_trig_addr", 32'(trig_addr), 32'(0));
    chk("t5_waddr", 32'(waddr), 32'(0));
    run_mode = 1'b0;
    ack();
    chk("t5_pulses", 32'(pulses), 32'(5));

    // Abort during POST, then run_mode dropped in PRE
    start_run(9'd380, 5'b11111);
    for (int k = 1; k <= 9; k++)
      strobe(k == 6);
    cap = 1'b0;
    chk("t6_armed_post", 32'(armed), 32'(1));
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t6_abort_idle", 32'(busy), 32'(0));
    chk("t6_abort_armed", 32'(armed), 32'(0));
    chk("t6_abort_waddr", 32'(waddr), 32'(9));
    chk("t6_abort_trig_addr", 32'(trig_addr), 32'(5));
    tick(1);
    chk("t6_restart_busy", 32'(busy), 32'(1));
    chk("t6_restart_waddr", 32'(waddr), 32'(0));
    m_addr = 0;
    cap = 1'b1;
    for (int k = 1; k <= 3; k++)
      strobe(1'b0);
    run_mode = 1'b0;
    cap = 1'b0;
    tick(1);
    chk("t6_drop_idle", 32'(busy), 32'(0));
    chk("t6_drop_armed", 32'(armed), 32'(0));
    chk("t6_drop_waddr", 32'(waddr), 32'(3));
    start_run(9'd380, 5'b11111);
    chk("t6_rerun_waddr", 32'(waddr), 32'(0));
    strobe(1'b0);
    run_mode = 1'b0;
    cap = 1'b0;
    tick(3);
    chk("t6_idle_end", 32'(busy), 32'(0));
    chk("t6_no_pulse", 32'(pulses), 32'(5));
    chk("t6_q_empty", 32'(exp_q.size()), 32'(0));

    // Continuous mode: auto re-arm after host handshake
    cont_mode = 1'b1;
    start_run(9'd380, 5'b11111);
    for (int k = 1; k <= 385; k++)
      strobe(k == 6);
    cap = 1'b0;
    chk("t7_scd_a", 32'(set_capture_done), 32'(1));
    chk("t7_waddr_a", 32'(waddr), 32'(1));
    ack();
    chk("t7_rearm_busy", 32'(busy), 32'(1));
    chk("t7_rearm_waddr", 32'(waddr), 32'(0));
    chk("t7_rearm_trig_addr", 32'(trig_addr), 32'(0));
    chk("t7_rearm_armed", 32'(armed), 32'(0));
    m_addr = 0;
    cap = 1'b1;
    for (int k = 1; k <= 385; k++)
      strobe(k == 6);
    cap = 1'b0;
    chk("t7_scd_b", 32'(set_capture_done), 32'(1));
    chk("t7_trig_addr_b", 32'(trig_addr), 32'(5));
    cont_mode = 1'b0;
    ack();
    chk("t7_idle", 32'(busy), 32'(0));
    run_mode = 1'b0;
    chk("t7_pulses", 32'(pulses), 32'(7));

    // Reset asserted mid-ARMED
    start_run(9'd380, 5'b11111);
    for (int k = 1; k <= 6; k++)
      strobe(1'b0);
    cap = 1'b0;
    chk("t8_armed", 32'(armed), 32'(1));
    rst_n = 1'b0;
    tick(1);
    chk("t8_rst_armed", 32'(armed), 32'(0));
    chk("t8_rst_scd", 32'(set_capture_done), 32'(0));
    chk("t8_rst_waddr", 32'(waddr), 32'(0));
    chk("t8_rst_trig_addr", 32'(trig_addr), 32'(0));
    chk("t8_rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    run_mode = 1'b0;
    strobe(1'b0);
    tick(1);
    chk("t8_q_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Parametrised multi-channel capture controller for the logic-analyzer datapath, sitting between the sample-rate/trigger logic and the per-channel RAM queues. It writes samples into a circular buffer and enforces a programmable pre-/post-trigger split. It arms the trigger only once the pre-trigger region is full, records the trigger sample's address for readout, and signals completion to the command/config block. It adds per-channel write masking, abort, clamping of out-of-range trigger positions, and continuous (auto re-arm) mode.

## Interface
- ENTRIES, 384, buffer depth in samples per channel (12288 on DE0)
- LOG2, 9, address width; 2**LOG2 >= ENTRIES
- NCHAN, 5, number of channel RAM queues
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- run_mode  in  1  start/continue capture (level)
- abort  in  1  cancel capture, highest priority
- cont_mode  in  1  re-arm automatically after host acknowledges capture
- trig_pos  in  LOG2  number of post-trigger samples, including the trigger sample
- chan_en  in  NCHAN  per-channel write mask
- wrt_smpl  in  1  sample strobe, one cycle per sample
- trig  in  1  trigger level from trigger logic
- capture_done  in  1  capture-done flag held by cmd_cfg until host readout
- armed  out  1  pre-trigger region full; trigger logic may fire
- set_capture_done  out  1  one-cycle pulse at end of capture
- we  out  NCHAN  RAM write enables
- waddr  out  LOG2  RAM write address; after completion, address of the oldest sample
- trig_addr  out  LOG2  address of the trigger sample
- busy  out  1  state != IDLE

## Operation
- Effective position: tp = 1 if trig_pos == 0; tp = ENTRIES if trig_pos > ENTRIES; otherwise tp = trig_pos. Pre-trigger requirement: need = ENTRIES - tp.
- Write rule: in PRE, ARMED and POST, each wrt_smpl gives we = chan_en (combinational, same cycle) at the current waddr. waddr then increments on the next edge and wraps from ENTRIES-1 to 0. Disabled channels never write, but counting still happens.
- States:
  - IDLE: no writes. run_mode=1 -> clear waddr, pre_cnt, post_cnt and trig_addr; go to PRE.
  - PRE: each write increments pre_cnt, saturating at ENTRIES. trig is ignored. When pre_cnt >= need, set armed and go to ARMED. A write in that same cycle still occurs.
  - ARMED: writes continue circularly. Trigger fires on the cycle where wrt_smpl && trig. That write occurs, trig_addr <= waddr, post_cnt <= 1. Next state is DONE_HI if tp == 1, else POST. trig without wrt_smpl is ignored.
  - POST: each write increments post_cnt. The write that makes post_cnt == tp is the final write; go to DONE_HI.
  - On entry to DONE_HI: set_capture_done = 1 for exactly one cycle and armed cleared, both on the same edge.
  - DONE_HI: no writes; wait for capture_done = 1, then go to DONE_LO.
  - DONE_LO: wait for capture_done = 0. Then, if cont_mode && run_mode, reset counters and go to PRE; otherwise go to IDLE.
- waddr and trig_addr hold from capture end until the next IDLE->PRE or DONE_LO->PRE transition.
- abort = 1, in any state: next state IDLE, armed = 0, no set_capture_done pulse, counters and addresses hold.
- run_mode = 0 in PRE, ARMED or POST: same effect as abort. run_mode is ignored in DONE_HI and DONE_LO.
- Arithmetic: the comparison pre_cnt >= need uses LOG2+1 bits, so no truncation occurs when ENTRIES = 2**LOG2.

## Timing
- Reset (rst_n low at a clock edge): state IDLE. armed, set_capture_done, waddr, trig_addr and busy are 0. we is 0 (it is gated by state).
- we has 0-cycle latency from wrt_smpl.
- armed rises 1 cycle after the edge where pre_cnt reaches need. Example: final pre write at cycle t, pre_cnt = need at t+1, armed = 1 at t+2.
- set_capture_done is high during the cycle after the final write's edge, for 1 cycle only.
- If wrt_smpl arrives on consecutive cycles, every strobe is written; no strobe is dropped in any capturing state, including state-change cycles.
- tp == ENTRIES: need = 0, so armed = 1 two cycles after run_mode.

## Test plan
- ENTRIES=384, trig_pos=100, strobe every cycle, trig asserted on write #300 (0-based addr 299):
  - armed stays 0 through write #284 and rises after it
  - trig_addr = 299
  - final write at addr 14
  - set_capture_done pulses once
  - waddr = 15
  - no we afterwards
- trig held high from start, trig_pos=100: writes 1-284 ignore trig. First armed write triggers, so trig_addr = 284.
- chan_en = 5'b00101: we only ever equals 5'b00101 or 0. Address sequence is identical to the all-enabled case.
- Out-of-range positions:
  - trig_pos = 0 behaves as 1: done immediately after the trigger write.
  - trig_pos = 511 behaves as 384: armed = 1 with zero pre writes, and 384 post writes wrap back to addr 0.
- abort during POST, and separately run_mode dropped in PRE:
  - IDLE next cycle
  - armed = 0
  - no set_capture_done
  - a new run_mode restarts at waddr = 0
- cont_mode = 1: capture_done is raised 2 cycles after the pulse, then lowered 10 cycles later. The controller re-enters PRE the cycle after the drop and completes a second capture. With cont_mode = 0 it returns to IDLE. Reset asserted mid-ARMED returns all outputs to 0.
